npc_gen: RTL and testbench

- Next-PC generator for the IFU front end. It holds the architectural fetch PC and issues fetch requests to IF0 over a valid/ready handshake.
- Each accepted request advances the PC sequentially to the next aligned fetch block.
- It consumes the arbitrated redirect (target plus valid) from the pcRedirect stage and applies it with priority over sequential advance.
- It honours a backpressure stall from the fetch queue and pulses a flush to the fetch stages when a redirect is taken.

---
 rtl/npc_gen_if.sv | 24 ++
 rtl/npc_gen.sv | 124 ++++++++++++
 tb/tb_npc_gen.sv | 136 +++++++++++++
 3 files changed

// File: rtl/npc_gen_if.sv
// IF0 fetch-request channel between the next-PC generator and IF0.
// The master drives the request and flush; the slave returns ready.
interface npc_gen_if #(
    parameter int MXLEN = 32
);
    logic [MXLEN-1:0] o_npcGen_if0_pc;
    logic             o_npcGen_if0_valid;
    logic             i_if0_npcGen_ready;
    logic             o_npcGen_if0_flush;

    modport master (
        output o_npcGen_if0_pc,
        output o_npcGen_if0_valid,
        output o_npcGen_if0_flush,
        input  i_if0_npcGen_ready
    );

    modport slave (
        input  o_npcGen_if0_pc,
        input  o_npcGen_if0_valid,
        input  o_npcGen_if0_flush,
        output i_if0_npcGen_ready
    );
endinterface

// File: rtl/npc_gen.sv
// Next-PC generator: holds the fetch PC, issues IF0 requests, and applies redirects with a flush pulse.
// Optional perf counters are included when NPCGEN_PERF_EN is defined.
//
// state | meaning
// BOOT  | one cycle out of reset, no request issued
// RUN   | request valid, advancing on acceptance
// STALL | fetch queue full, no request issued
module npc_gen #(
    parameter int               MXLEN       = 32,
    parameter logic [MXLEN-1:0] RESET_VEC   = 'h8000_0000,
    parameter int               FETCH_BYTES = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [MXLEN-1:0] i_pcRedirect_npcGen_npc,
    input  logic             i_pcRedirect_npcGen_redirect_valid,
    input  logic             i_ftq_npcGen_stall,
    npc_gen_if.master        if0,
`ifdef NPCGEN_PERF_EN
    output logic [31:0]      o_npcGen_perf_fetch_cnt,
    output logic [31:0]      o_npcGen_perf_redirect_cnt,
    output logic [31:0]      o_npcGen_perf_stall_cnt,
`endif
    output logic [1:0]       o_npcGen_state
);

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;

    localparam logic [MXLEN-1:0] BLK      = MXLEN'(FETCH_BYTES);
    localparam logic [MXLEN-1:0] BLK_MASK = ~(BLK - 1'b1);

    logic [1:0]       state_q, state_d;
    logic [MXLEN-1:0] pc_q, pc_d;
    logic             flush_q, flush_d;

    logic             valid;
    logic             accept;
    logic             redirect_taken;
    logic [MXLEN-1:0] seq_pc;

    assign valid          = (state_q == ST_RUN);
    assign accept         = valid && if0.i_if0_npcGen_ready;
    assign redirect_taken = i_pcRedirect_npcGen_redirect_valid &&
                            ((state_q == ST_RUN) || (state_q == ST_STALL));
    // Wraps silently at the top of the address space.
    assign seq_pc         = (pc_q & BLK_MASK) + BLK;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flush_d = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
                if (i_pcRedirect_npcGen_redirect_valid) pc_d = i_pcRedirect_npcGen_npc;
            end
            ST_RUN: begin
                if (i_pcRedirect_npcGen_redirect_valid) begin
                    pc_d    = i_pcRedirect_npcGen_npc;
                    flush_d = 1'b1;
                end else if (accept) begin
                    pc_d = seq_pc;
                end
                // A redirect also retires the pending request, so stall may take effect.
                if (i_ftq_npcGen_stall && (accept || i_pcRedirect_npcGen_redirect_valid))
                    state_d = ST_STALL;
            end
            ST_STALL: begin
                if (i_pcRedirect_npcGen_redirect_valid) begin
                    pc_d    = i_pcRedirect_npcGen_npc;
                    flush_d = 1'b1;
                end
                if (!i_ftq_npcGen_stall) state_d = ST_RUN;
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_VEC;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flush_q <= flush_d;
        end
    end

    assign if0.o_npcGen_if0_pc    = pc_q;
    assign if0.o_npcGen_if0_valid = valid;
    assign if0.o_npcGen_if0_flush = flush_q;
    assign o_npcGen_state         = state_q;

`ifdef NPCGEN_PERF_EN
    logic [31:0] fetch_cnt_q, redirect_cnt_q, stall_cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_cnt_q    <= '0;
            redirect_cnt_q <= '0;
            stall_cnt_q    <= '0;
        end else begin
            if (accept && (fetch_cnt_q != 32'hFFFF_FFFF))
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (redirect_taken && (redirect_cnt_q != 32'hFFFF_FFFF))
                redirect_cnt_q <= redirect_cnt_q + 32'd1;
            if ((state_q == ST_STALL) && (stall_cnt_q != 32'hFFFF_FFFF))
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign o_npcGen_perf_fetch_cnt    = fetch_cnt_q;
    assign o_npcGen_perf_redirect_cnt = redirect_cnt_q;
    assign o_npcGen_perf_stall_cnt    = stall_cnt_q;
`else
    logic unused_redirect_taken;
    assign unused_redirect_taken = redirect_taken;
`endif

endmodule

// File: tb/tb_npc_gen.sv
// Directed bench for npc_gen: boot, redirects, hold, stall, wrap and mid-run reset.
module tb_npc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rd_npc;
    logic        rd_valid;
    logic        stall;
    logic [1:0]  state;
    int          n_chk = 0;
    int          n_err = 0;

`ifdef NPCGEN_PERF_EN
    logic [31:0] perf_fetch, perf_redir, perf_stall;
`endif

    npc_gen_if #(.MXLEN(32)) u_if ();

    npc_gen #(
        .MXLEN       (32),
        .RESET_VEC   (32'h8000_0000),
        .FETCH_BYTES (16)
    ) u_dut (
        .i_clk                              (clk),
        .i_rst                              (rst),
        .i_pcRedirect_npcGen_npc            (rd_npc),
        .i_pcRedirect_npcGen_redirect_valid (rd_valid),
        .i_ftq_npcGen_stall                 (stall),
        .if0                                (u_if.master),
`ifdef NPCGEN_PERF_EN
        .o_npcGen_perf_fetch_cnt            (perf_fetch),
        .o_npcGen_perf_redirect_cnt         (perf_redir),
        .o_npcGen_perf_stall_cnt            (perf_stall),
`endif
        .o_npcGen_state                     (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%08h expected 'h%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] pc, input logic v,
                              input logic fl, input logic [1:0] st);
        chk({tag, ".pc"},    u_if.o_npcGen_if0_pc, pc);
        chk({tag, ".valid"}, {31'd0, u_if.o_npcGen_if0_valid}, {31'd0, v});
        chk({tag, ".flush"}, {31'd0, u_if.o_npcGen_if0_flush}, {31'd0, fl});
        chk({tag, ".state"}, {30'd0, state}, {30'd0, st});
    endtask

    initial begin
        rst      = 1'b1;
        rd_npc   = '0;
        rd_valid = 1'b0;
        stall    = 1'b0;
        u_if.i_if0_npcGen_ready = 1'b1;

        // Boot
        repeat (3) step();
        rst = 1'b0;
        expect_out("boot0", 32'h8000_0000, 1'b0, 1'b0, 2'd0);
`ifdef NPCGEN_PERF_EN
        chk("perf_fetch_rst", perf_fetch, 32'd0);
`endif
        step(); expect_out("boot1", 32'h8000_0000, 1'b1, 1'b0, 2'd1);
        step(); expect_out("boot2", 32'h8000_0010, 1'b1, 1'b0, 2'd1);
        step(); expect_out("boot3", 32'h8000_0020, 1'b1, 1'b0, 2'd1);

        // Unaligned redirect in an accepting cycle
        rd_valid = 1'b1; rd_npc = 32'h8000_0106;
        step(); expect_out("unal0", 32'h8000_0106, 1'b1, 1'b1, 2'd1);
        rd_valid = 1'b0;
        step(); expect_out("unal1", 32'h8000_0110, 1'b1, 1'b0, 2'd1);

        // Hold for three cycles, redirect in the third
        rd_valid = 1'b1; rd_npc = 32'h8000_0040;
        step(); expect_out("hold1", 32'h8000_0040, 1'b1, 1'b1, 2'd1);
        rd_valid = 1'b0; u_if.i_if0_npcGen_ready = 1'b0;
        step(); expect_out("hold2", 32'h8000_0040, 1'b1, 1'b0, 2'd1);
        step(); expect_out("hold3", 32'h8000_0040, 1'b1, 1'b0, 2'd1);
        rd_valid = 1'b1; rd_npc = 32'h9000_0000;
        step(); expect_out("hold_rd", 32'h9000_0000, 1'b1, 1'b1, 2'd1);
        rd_valid = 1'b0;

        // Stall with a pending request, redirect while stalled
        stall = 1'b1;
        step(); expect_out("stl_pend", 32'h9000_0000, 1'b1, 1'b0, 2'd1);
        u_if.i_if0_npcGen_ready = 1'b1;
        step(); expect_out("stl_enter", 32'h9000_0010, 1'b0, 1'b0, 2'd2);
        rd_valid = 1'b1; rd_npc = 32'h0000_1234;
        step(); expect_out("stl_rd", 32'h0000_1234, 1'b0, 1'b1, 2'd2);
        rd_valid = 1'b0; stall = 1'b0;
        step(); expect_out("stl_exit", 32'h0000_1234, 1'b1, 1'b0, 2'd1);

        // Wrap at the top of the address space
        rd_valid = 1'b1; rd_npc = 32'hFFFF_FFF4;
        step(); expect_out("wrap0", 32'hFFFF_FFF4, 1'b1, 1'b1, 2'd1);
        rd_valid = 1'b0;
        step(); expect_out("wrap1", 32'h0000_0000, 1'b1, 1'b0, 2'd1);

        // Reset mid-operation with a pending request
        rd_valid = 1'b1; rd_npc = 32'h9000_0010; u_if.i_if0_npcGen_ready = 1'b0;
        step(); expect_out("mid_pend", 32'h9000_0010, 1'b1, 1'b1, 2'd1);
        rd_valid = 1'b0; rst = 1'b1;
        step(); expect_out("mid_rst", 32'h8000_0000, 1'b0, 1'b0, 2'd0);
`ifdef NPCGEN_PERF_EN
        chk("perf_fetch_mid", perf_fetch, 32'd0);
        chk("perf_redir_mid", perf_redir, 32'd0);
        chk("perf_stall_mid", perf_stall, 32'd0);
`endif

        // Redirect during BOOT, then back-to-back redirects
        rst = 1'b0; rd_valid = 1'b1; rd_npc = 32'h8000_0200; u_if.i_if0_npcGen_ready = 1'b1;
        step(); expect_out("boot_rd", 32'h8000_0200, 1'b1, 1'b0, 2'd1);
        rd_npc = 32'h8000_0300;
        step(); expect_out("b2b0", 32'h8000_0300, 1'b1, 1'b1, 2'd1);
        rd_npc = 32'h8000_0400;
        step(); expect_out("b2b1", 32'h8000_0400, 1'b1, 1'b1, 2'd1);
        rd_valid = 1'b0;
        step(); expect_out("b2b2", 32'h8000_0410, 1'b1, 1'b0, 2'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
